// File: rtl/pipo_pkg.sv
// Shared constants for the parallel-in/parallel-out register family.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package pipo_pkg;

    // Default data width of a holding stage.
    localparam int PIPO_DEFAULT_WIDTH = 4;

    // Default word forced onto q while reset is held.
    localparam logic [PIPO_DEFAULT_WIDTH-1:0] PIPO_DEFAULT_RST = '0;

endpackage : pipo_pkg

// File: rtl/dff_arn.sv
// Single-bit rising-edge flop with asynchronous active-low reset to a fixed bit value.
// Latency: 1 clk from d to q.
// Backpressure: none; captures on every rising edge while out of reset.
module dff_arn #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Reset clears to RST_BIT at once; otherwise sample d on each rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_BIT;
        end else begin
            q <= d;
        end
    end

endmodule : dff_arn

// File: rtl/pipo_posedge.sv
// Parallel-in/parallel-out WIDTH-bit holding register between combinational blocks.
// Latency: exactly 1 clk from d to q; no combinational path.
// Backpressure: none; no load enable, a new word is taken on every rising edge.
module pipo_posedge
    import pipo_pkg::*;
#(
    parameter int               WIDTH   = PIPO_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(PIPO_DEFAULT_RST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // One flop per bit, each with its own reset bit taken from RST_VAL,
    // so every bit is captured in parallel with no reordering.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_arn #(
            .RST_BIT (RST_VAL[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .q   (q[i])
        );
    end

endmodule : pipo_posedge

// File: tb/tb_pipo_posedge.sv
module tb_pipo_posedge;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d4;
    logic [3:0] q4;
    logic [7:0] d8;
    logic [7:0] q8;

    // reference: the word q must show, per instance
    logic [3:0] e4;
    logic [7:0] e8;

    localparam logic [3:0] RST4 = 4'h0;
    localparam logic [7:0] RST8 = 8'hA5;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipo_posedge u_dut4 (
        .clk (clk),
        .rst (rst),
        .d   (d4),
        .q   (q4)
    );

    pipo_posedge #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .d   (d8),
        .q   (q8)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "/w4"}, {4'h0, q4}, {4'h0, e4});
        check({tag, "/w8"}, q8, e8);
    endtask

    // One clock cycle: at the low phase apply reset level and data, confirm q
    // has not followed d (or has been reset at once), then confirm the word
    // seen at the rising edge lands on q.
    task automatic cycle(input string tag, input logic nr, input logic [3:0] n4, input logic [7:0] n8);
        @(negedge clk);
        #1;
        rst = nr;
        d4  = n4;
        d8  = n8;
        if (!nr) begin
            e4 = RST4;
            e8 = RST8;
        end
        #1;
        check_both({tag, "_mid"});
        @(posedge clk);
        #1;
        if (rst) begin
            e4 = n4;
            e8 = n8;
        end
        check_both(tag);
    endtask

    initial begin
        rst = 1'b1;
        d4  = 4'b1010;
        d8  = 8'h3C;
        #1;
        rst = 1'b0;
        e4  = RST4;
        e8  = RST8;
        #1;
        check_both("reset_init");

        // held in reset while clock runs: no capture
        repeat (3) cycle("reset_hold", 1'b0, 4'b1010, 8'h3C);

        // release: first rising edge captures
        cycle("release", 1'b1, 4'b1010, 8'h3C);
        cycle("seq_0010", 1'b1, 4'b0010, 8'h12);
        cycle("seq_0001", 1'b1, 4'b0001, 8'h81);

        // reset dropped between edges clears immediately
        cycle("async_rst", 1'b0, 4'b0111, 8'h77);
        cycle("rst_again", 1'b1, 4'b1100, 8'hC3);

        // d changed just before a falling edge: q unchanged until rising edge
        @(posedge clk);
        #1;
        e4 = 4'b1100;
        e8 = 8'hC3;
        check_both("pre_fall_base");
        #3;
        d4 = 4'b0110;
        d8 = 8'h66;
        @(negedge clk);
        #1;
        check_both("post_fall");
        @(posedge clk);
        #1;
        e4 = 4'b0110;
        e8 = 8'h66;
        check_both("post_rise");

        // back-to-back words
        cycle("b2b_F", 1'b1, 4'hF, 8'hFF);
        cycle("b2b_0", 1'b1, 4'h0, 8'h00);
        cycle("b2b_5", 1'b1, 4'h5, 8'h55);

        // random data with occasional mid-cycle resets
        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 15) != 0), 4'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_pipo_posedge
